sr_pulse_sequencer: RTL and testbench
=====================================

// Module: sr_pulse_sequencer
// PURPOSE
//  - Sequences set/clear commands from two requesters onto one external SR latch (s, r inputs).
//  - Arbitrates round-robin and drives timed s or r pulses; s=r=1 is never driven.
//  - Enforces an idle gap (s=r=0) after every pulse and keeps a shadow copy of the latch value.
//  - Sits between control logic and the latch; optionally checks the latch's q/q_bar feedback.
// PARAMETERS
//  PULSE_W  2  cycles s or r is held high per command (>=1)
//  GAP_W    1  cycles s=r=0 after each pulse before the next grant (>=1)
// PORTS
//  clk       in   1  single clock, rising edge
//  reset     in   1  synchronous, active-high reset
//  req_a     in   1  requester A command request; hold high until ack_a
//  op_a      in   1  requester A op: 1=set, 0=clear; stable while req_a high
//  ack_a     out  1  one-cycle grant pulse to A
//  req_b     in   1  requester B command request; hold high until ack_b
//  op_b      in   1  requester B op: 1=set, 0=clear
//  ack_b     out  1  one-cycle grant pulse to B
//  s         out  1  latch set drive
//  r         out  1  latch reset drive
//  q_fb      in   1  latch q feedback
//  q_bar_fb  in   1  latch q_bar feedback
//  busy      out  1  high whenever FSM is not IDLE
//  shadow_q  out  1  expected latch value after the last completed pulse
//  err       out  1  sticky feedback-mismatch flag
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: s=0, r=0, ack_a=0, ack_b=0, busy=0, shadow_q=0, err=0; FSM=IDLE; rr pointer favours A.
//  - Reset mid-pulse aborts immediately: s/r drop at the next edge; no ack is issued for the aborted command.
//  - FSM states: IDLE -> PULSE -> GAP -> IDLE.
//  - IDLE: on an edge with req_a|req_b sampled, grant one requester:
//    - Only one requesting: grant it.
//    - Both requesting: grant the one not granted last (after reset A wins first).
//    - Latch the winner's op; set ack_x=1 for exactly one cycle.
//    - Drive s=op, r=~op from that same cycle; load cnt=PULSE_W-1; go to PULSE.
//  - PULSE: hold s/r.
//    - cnt>0: decrement.
//    - cnt==0: next cycle s=r=0, shadow_q<=op, cnt=GAP_W-1, go to GAP.
//    - s/r are high for exactly PULSE_W cycles.
//  - GAP: s=r=0.
//    - cnt>0: decrement.
//    - cnt==0: go to IDLE.
//    - GAP lasts exactly GAP_W cycles.
//  - IDLE is one cycle minimum, so back-to-back grants are PULSE_W+GAP_W+1 cycles apart.
//  - Latency: req sampled at edge N -> ack and s/r high at edge N+1.
//  - busy is high from edge N+1 until the IDLE re-entry edge.
//  - Requester drops req in the ack cycle. A req still high on IDLE re-entry is a new command.
//  - Requests arriving outside IDLE are not sampled; they wait.
//  - A command equal to shadow_q is still pulsed, never skipped.
//  - Invariant: s&r==0 in every cycle, including across reset.
//  - Counter width: $clog2(max(PULSE_W,GAP_W)+1).
// CONFIGURATION
//  SR_CHECK_EN defined:
//    - On the GAP->IDLE edge, compare q_fb against shadow_q and q_bar_fb against ~shadow_q.
//    - Any mismatch sets err=1; err is sticky until reset.
//  SR_CHECK_EN undefined:
//    - err is tied 0; q_fb/q_bar_fb are unused.
//    - All other timing is identical.
// TESTING
//  1. reset=1 for 2 cycles, drive s/r from any state -> s=r=0, shadow_q=0, busy=0, ack_a=ack_b=0.
//  2. PULSE_W=2, GAP_W=1: req_a=1,op_a=1 at edge 0 -> ack_a=1 at 1 only; s=1 at 1-2;
//     s=r=0 at 3; shadow_q=1 from 3; busy low at 4.
//  3. req_a and req_b both held, op_a=1, op_b=0 -> A granted first, B granted 4 cycles later;
//     r=1 for 2 cycles; final shadow_q=0.
//  4. Both requesters hold req for 4 commands each -> grants strictly alternate A,B,A,B...;
//     s&r is never 1 (assertion).
//  5. reset asserted in the 2nd PULSE cycle of a set -> s=0 next edge, shadow_q=0;
//     command is not retried unless req is reasserted.
//  6. SR_CHECK_EN defined: set command with q_fb held 0 -> err=1 on the GAP->IDLE edge, stays 1 until reset.
//     Undefined: err stays 0.

Source files
------------

// File: rtl/sr_pulse_sequencer.sv
// Round-robin sequencer driving timed set/reset pulses onto one external SR latch.
// Optional latch feedback check is enabled by defining SR_CHECK_EN.
module sr_pulse_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic op_a,
    output logic ack_a,
    input  logic req_b,
    input  logic op_b,
    output logic ack_b,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic q_bar_fb,
    output logic busy,
    output logic shadow_q,
    output logic err
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             op_r, op_nxt_s;
    logic             prefer_b_r, prefer_b_nxt_s;
    logic             s_r, s_nxt_s;
    logic             r_r, r_nxt_s;
    logic             ack_a_r, ack_a_nxt_s;
    logic             ack_b_r, ack_b_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             shadow_r, shadow_nxt_s;
    logic             err_r, err_nxt_s;
    logic             grant_a_s, grant_b_s, op_sel_s;
    logic             fb_bad_s;

    // Round-robin pick; prefer_b_r is set once A has been served last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (req_a && (!req_b || !prefer_b_r)) begin
            grant_a_s = 1'b1;
        end else if (req_b) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
        end
        op_sel_s = grant_a_s ? op_a : op_b;
    end

`ifdef SR_CHECK_EN
    // Feedback must match the shadow copy in both rails.
    always_comb begin
        fb_bad_s = (q_fb != shadow_r) || (q_bar_fb != ~shadow_r);
    end
`else
    wire unused_fb_s = &{1'b0, q_fb, q_bar_fb};
    // Feedback checking compiled out.
    always_comb begin
        fb_bad_s = 1'b0;
    end
`endif

    // State and registered outputs; reset drops s/r at the very next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            op_r       <= 1'b0;
            prefer_b_r <= 1'b0;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            ack_a_r    <= 1'b0;
            ack_b_r    <= 1'b0;
            busy_r     <= 1'b0;
            shadow_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            op_r       <= op_nxt_s;
            prefer_b_r <= prefer_b_nxt_s;
            s_r        <= s_nxt_s;
            r_r        <= r_nxt_s;
            ack_a_r    <= ack_a_nxt_s;
            ack_b_r    <= ack_b_nxt_s;
            busy_r     <= busy_nxt_s;
            shadow_r   <= shadow_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_a || req_b) state_nxt_s = ST_PULSE;
                else                state_nxt_s = ST_IDLE;
            end
            ST_PULSE: begin
                if (cnt_r == CNT_ZERO) state_nxt_s = ST_GAP;
                else                   state_nxt_s = ST_PULSE;
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_GAP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        cnt_nxt_s      = cnt_r;
        op_nxt_s       = op_r;
        prefer_b_nxt_s = prefer_b_r;
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        ack_a_nxt_s    = 1'b0;
        ack_b_nxt_s    = 1'b0;
        busy_nxt_s     = 1'b0;
        shadow_nxt_s   = shadow_r;
        err_nxt_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    ack_a_nxt_s    = grant_a_s;
                    ack_b_nxt_s    = grant_b_s;
                    op_nxt_s       = op_sel_s;
                    s_nxt_s        = op_sel_s;
                    r_nxt_s        = ~op_sel_s;
                    cnt_nxt_s      = PULSE_LD;
                    prefer_b_nxt_s = grant_a_s;
                    busy_nxt_s     = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_PULSE: begin
                busy_nxt_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    shadow_nxt_s = op_r;
                    cnt_nxt_s    = GAP_LD;
                end else begin
                    s_nxt_s   = op_r;
                    r_nxt_s   = ~op_r;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    busy_nxt_s = 1'b0;
                    err_nxt_s  = err_r | fb_bad_s;
                end else begin
                    busy_nxt_s = 1'b1;
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    assign s        = s_r;
    assign r        = r_r;
    assign ack_a    = ack_a_r;
    assign ack_b    = ack_b_r;
    assign busy     = busy_r;
    assign shadow_q = shadow_r;
    assign err      = err_r;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Directed self-checking bench for sr_pulse_sequencer (PULSE_W=2, GAP_W=1).
module tb_sr_pulse_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
    logic ack_a, ack_b, s, r, busy, shadow_q, err;
    logic q_fb, q_bar_fb;
    logic lat_q = 1'b0;
    logic fb_break = 1'b0;
    int   n_checks = 0;
    int   n_bad = 0;

`ifdef SR_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    sr_pulse_sequencer #(.PULSE_W(2), .GAP_W(1)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .op_a(op_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .ack_b(ack_b),
        .s(s), .r(r), .q_fb(q_fb), .q_bar_fb(q_bar_fb),
        .busy(busy), .shadow_q(shadow_q), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external latch.
    always @(posedge clk) begin
        if (s)      lat_q <= 1'b1;
        else if (r) lat_q <= 1'b0;
    end
    assign q_fb     = fb_break ? 1'b0 : lat_q;
    assign q_bar_fb = ~q_fb;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_val("s_r_excl", {31'd0, s & r}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic e_s, input logic e_r, input logic e_aa,
                             input logic e_ab, input logic e_busy, input logic e_sh);
        check_val({tag, "_s"}, {31'd0, s}, {31'd0, e_s});
        check_val({tag, "_r"}, {31'd0, r}, {31'd0, e_r});
        check_val({tag, "_ack_a"}, {31'd0, ack_a}, {31'd0, e_aa});
        check_val({tag, "_ack_b"}, {31'd0, ack_b}, {31'd0, e_ab});
        check_val({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
        check_val({tag, "_shadow"}, {31'd0, shadow_q}, {31'd0, e_sh});
    endtask

    initial begin
        // Reset state
        req_a = 1'b1; op_a = 1'b1;
        do_reset();
        req_a = 1'b0;
        check_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_err", {31'd0, err}, 32'd0);

        // Single set from A
        req_a = 1'b1; op_a = 1'b1;
        tick(); check_out("set_e1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        req_a = 1'b0;
        tick(); check_out("set_e2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); check_out("set_e3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); check_out("set_e4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("set_err", {31'd0, err}, 32'd0);

        // Both requesting: A first, B four cycles later with a clear
        do_reset();
        req_a = 1'b1; op_a = 1'b1; req_b = 1'b1; op_b = 1'b0;
        tick(); check_out("both_e1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        req_a = 1'b0;
        tick(); tick();
        tick(); check_out("both_e4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); check_out("both_e5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        req_b = 1'b0;
        tick(); check_out("both_e6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); check_out("both_e7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); check_out("both_e8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous requests from both: strict alternation
        do_reset();
        req_a = 1'b1; op_a = 1'b1; req_b = 1'b1; op_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("rr_ack_a_%0d", k), {31'd0, ack_a}, {31'd0, ~k[0]});
            check_val($sformatf("rr_ack_b_%0d", k), {31'd0, ack_b}, {31'd0, k[0]});
            check_val($sformatf("rr_s_%0d", k), {31'd0, s}, {31'd0, ~k[0]});
            if (k == 6) req_a = 1'b0;
            if (k == 7) req_b = 1'b0;
            tick(); tick(); tick();
        end
        tick(); check_out("rr_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Repeat set while shadow is already 1, then reset mid-pulse
        do_reset();
        req_a = 1'b1; op_a = 1'b1;
        tick(); req_a = 1'b0;
        tick(); tick(); tick();
        check_val("abort_pre_shadow", {31'd0, shadow_q}, 32'd1);
        req_a = 1'b1;
        tick(); check_out("same_op_e1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        req_a = 1'b0;
        tick();
        reset = 1'b1;
        tick(); check_out("abort_e1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); check_out("abort_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        check_out("abort_e4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Broken feedback: err is sticky when checking is built in
        do_reset();
        fb_break = 1'b1;
        req_a = 1'b1; op_a = 1'b1;
        tick(); req_a = 1'b0;
        tick(); tick();
        check_val("fb_err_e3", {31'd0, err}, 32'd0);
        tick(); check_val("fb_err_e4", {31'd0, err}, {31'd0, ERR_ON});
        tick(); tick();
        check_val("fb_err_sticky", {31'd0, err}, {31'd0, ERR_ON});
        fb_break = 1'b0;
        do_reset();
        check_val("fb_err_rst", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
